// File: rtl/pwr_sched_pkg.sv
// Shared constants, tag record and FSM encoding for the lane-sharing power scheduler.
package pwr_sched_pkg;

  localparam int DATA_W   = 23;
  localparam int PROD_W   = 46;
  localparam int PWR_W    = 48;
  localparam int PIPE_LAT = 4;

  // Tag fields are sized for the largest supported configuration (8 lanes, 64k bins).
  localparam int TAG_LANE_W = 3;
  localparam int TAG_BIN_W  = 16;

  typedef struct packed {
    logic [TAG_LANE_W-1:0] lane;
    logic [TAG_BIN_W-1:0]  bin;
    logic                  sof;
  } tag_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/pwr_sq_pipe.sv
// re^2 + im^2 datapath: three register stages around the multipliers, one after the adder.
module pwr_sq_pipe
  import pwr_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     sclr,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic [PWR_W-1:0]         power
);

  logic signed [DATA_W-1:0] re_q, im_q;
  logic signed [PROD_W-1:0] re2_q, im2_q, re2_qq, im2_qq;

  // Squares are never negative, so zero extension of the products is exact.
  always_ff @(posedge clk) begin
    if (sclr) begin
      re_q   <= '0;
      im_q   <= '0;
      re2_q  <= '0;
      im2_q  <= '0;
      re2_qq <= '0;
      im2_qq <= '0;
      power  <= '0;
    end else begin
      re_q   <= re;
      im_q   <= im;
      re2_q  <= PROD_W'(re_q) * PROD_W'(re_q);
      im2_q  <= PROD_W'(im_q) * PROD_W'(im_q);
      re2_qq <= re2_q;
      im2_qq <= im2_q;
      power  <= PWR_W'($unsigned(re2_qq)) + PWR_W'($unsigned(im2_qq));
    end
  end

endmodule

// File: rtl/pwr_lane_sched.sv
// Frame-locked round-robin scheduler: one lane owns the squarer for a whole FFT frame.
module pwr_lane_sched
  import pwr_sched_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int FFT_POINT = 512,
  parameter int BIN_W     = 9,
  parameter int LANE_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        s_valid,
  output logic [NUM_LANES-1:0]        s_ready,
  input  logic [NUM_LANES-1:0]        s_sof,
  input  logic [NUM_LANES*DATA_W-1:0] s_re,
  input  logic [NUM_LANES*DATA_W-1:0] s_im,
  output logic                        m_valid,
  output logic [LANE_W-1:0]           m_lane,
  output logic [BIN_W-1:0]            m_bin,
  output logic                        m_sof,
  output logic [PWR_W-1:0]            m_power,
  output logic [NUM_LANES-1:0]        err
);

  state_t                   state_q;
  logic [LANE_W-1:0]        ptr_q, g_q, sel, grant_idx, idx;
  logic [BIN_W-1:0]         cnt_q;
  logic [NUM_LANES-1:0]     err_q, disc, mid_err;
  logic                     grant_found, beat, sel_sof;
  logic signed [DATA_W-1:0] sq_re, sq_im;
  tag_t                     tag_in, out_tag;
  tag_t                     tag_q [PIPE_LAT];
  logic [PIPE_LAT-1:0]      vld_q;
  logic [$bits(tag_t)-1:0]  unused_tag;

  always_comb begin
    s_ready     = '0;
    disc        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    beat        = 1'b0;
    sel         = '0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        for (int unsigned d = 0; d < NUM_LANES; d++) begin
          idx = LANE_W'((32'(ptr_q) + d) % NUM_LANES);
          if (!grant_found && s_valid[idx] && s_sof[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
          end
        end
        // Non-SOF samples arriving while idle are drained so the lane cannot lock up.
        disc    = s_valid & ~s_sof;
        s_ready = disc;
        if (grant_found) s_ready[grant_idx] = 1'b1;
        beat = grant_found;
        sel  = grant_idx;
      end else begin
        s_ready[g_q] = 1'b1;
        beat         = s_valid[g_q];
        sel          = g_q;
      end
    end
  end

  // The grant beat in IDLE carries SOF, so one tag rule covers both grant and mid-frame restart.
  always_comb begin
    sel_sof = s_sof[sel];
    sq_re   = '0;
    sq_im   = '0;
    tag_in  = '0;
    mid_err = '0;
    if (beat) begin
      sq_re       = s_re[int'(sel)*DATA_W +: DATA_W];
      sq_im       = s_im[int'(sel)*DATA_W +: DATA_W];
      tag_in.lane = TAG_LANE_W'(sel);
      tag_in.bin  = sel_sof ? '0 : TAG_BIN_W'(cnt_q);
      tag_in.sof  = sel_sof || (cnt_q == '0);
      if (state_q == ST_BURST && sel_sof && cnt_q != '0) mid_err[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      err_q    <= err_q | disc | mid_err;
      vld_q    <= {vld_q[PIPE_LAT-2:0], beat};
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (state_q == ST_IDLE) begin
        if (grant_found) begin
          g_q     <= grant_idx;
          state_q <= ST_BURST;
          cnt_q   <= BIN_W'(1);
        end
      end else if (beat) begin
        if (sel_sof) begin
          cnt_q <= BIN_W'(1);
        end else if (cnt_q == BIN_W'(FFT_POINT-1)) begin
          state_q <= ST_IDLE;
          ptr_q   <= (g_q == LANE_W'(NUM_LANES-1)) ? '0 : g_q + LANE_W'(1);
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + BIN_W'(1);
        end
      end
    end
  end

  pwr_sq_pipe u_sq (
    .clk   (clk),
    .sclr  (rst),
    .re    (sq_re),
    .im    (sq_im),
    .power (m_power)
  );

  assign out_tag    = tag_q[PIPE_LAT-1];
  assign unused_tag = out_tag;
  assign m_valid    = vld_q[PIPE_LAT-1];
  assign m_lane     = out_tag.lane[LANE_W-1:0];
  assign m_bin      = out_tag.bin[BIN_W-1:0];
  assign m_sof      = out_tag.sof;
  assign err        = err_q;

endmodule

// File: tb/tb_pwr_lane_sched.sv
// Randomized bench for pwr_lane_sched against a frame-level reference model.
module tb_pwr_lane_sched;

  localparam int N  = 4;
  localparam int FP = 512;
  localparam int BW = 9;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid, s_ready, s_sof, err;
  logic [N*23-1:0] s_re, s_im;
  logic            m_valid, m_sof;
  logic [LW-1:0]   m_lane;
  logic [BW-1:0]   m_bin;
  logic [47:0]     m_power;

  pwr_lane_sched #(.NUM_LANES(N), .FFT_POINT(FP), .BIN_W(BW), .LANE_W(LW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_re(s_re), .s_im(s_im), .m_valid(m_valid), .m_lane(m_lane), .m_bin(m_bin),
    .m_sof(m_sof), .m_power(m_power), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-lane frame sources
  int  gen_frames[N];
  int  gen_pos[N];
  int  gen_pv[N];
  int  gen_resof[N];
  int  gen_fre[N];
  int  gen_fim[N];
  bit  gen_toggle[N];
  bit  gen_fixed[N];
  bit  tog_ph[N];
  logic signed [22:0] in_re[N];
  logic signed [22:0] in_im[N];

  // Reference model
  typedef struct { bit v; int lane; int bin; bit sof; longint pwr; } res_t;
  res_t     pipe_q[$];
  res_t     cur;
  bit       md_busy, md_beat;
  int       md_owner, md_ptr, md_bin, md_lane;
  logic [N-1:0] exp_ready, md_disc, md_err;

  task automatic pack_inputs();
    for (int k = 0; k < N; k++) begin
      s_re[23*k +: 23] = in_re[k];
      s_im[23*k +: 23] = in_im[k];
    end
  endtask

  task automatic gen_inputs();
    for (int k = 0; k < N; k++) begin
      s_valid[k] = 1'b0;
      s_sof[k]   = 1'b0;
      in_re[k]   = 23'($urandom);
      in_im[k]   = 23'($urandom);
      if (gen_frames[k] > 0) begin
        s_valid[k] = gen_toggle[k] ? tog_ph[k] : ($urandom_range(99) < gen_pv[k]);
        tog_ph[k]  = !tog_ph[k];
        s_sof[k]   = (gen_pos[k] == 0) || (gen_pos[k] == gen_resof[k]);
        if (gen_fixed[k]) begin
          in_re[k] = 23'(gen_fre[k]);
          in_im[k] = 23'(gen_fim[k]);
        end
      end
    end
    pack_inputs();
  endtask

  task automatic gen_clear();
    for (int k = 0; k < N; k++) begin
      gen_frames[k] = 0; gen_pos[k] = 0; gen_pv[k] = 100; gen_resof[k] = -1;
      gen_toggle[k] = 0; gen_fixed[k] = 0; tog_ph[k] = 1;
    end
  endtask

  task automatic model_comb();
    int win;
    exp_ready = '0; md_disc = '0; md_beat = 0; md_lane = 0; win = -1;
    if (!rst) begin
      if (!md_busy) begin
        for (int d = 0; d < N; d++) begin
          int k = (md_ptr + d) % N;
          if (win < 0 && s_valid[k] && s_sof[k]) win = k;
        end
        for (int k = 0; k < N; k++) if (s_valid[k] && !s_sof[k]) md_disc[k] = 1'b1;
        exp_ready = md_disc;
        if (win >= 0) begin exp_ready[win] = 1'b1; md_beat = 1; md_lane = win; end
      end else begin
        exp_ready[md_owner] = 1'b1;
        md_beat = s_valid[md_owner];
        md_lane = md_owner;
      end
    end
    #1;
  endtask

  task automatic advance();
    res_t r, z;
    longint a, b;
    z = '{v: 0, lane: 0, bin: 0, sof: 0, pwr: 0};
    @(posedge clk);
    if (rst) begin
      md_busy = 0; md_ptr = 0; md_bin = 0; md_owner = 0; md_err = '0;
      pipe_q.delete();
      repeat (3) pipe_q.push_back(z);
      cur = z;
    end else begin
      r = z;
      md_err = md_err | md_disc;
      if (md_beat) begin
        a = longint'(in_re[md_lane]);
        b = longint'(in_im[md_lane]);
        r.v = 1; r.lane = md_lane; r.pwr = a*a + b*b;
        if (!md_busy || s_sof[md_lane]) begin
          if (md_busy && md_bin != 0) md_err[md_lane] = 1'b1;
          md_busy = 1; md_owner = md_lane; r.bin = 0; r.sof = 1; md_bin = 1;
        end else begin
          r.bin = md_bin; r.sof = (md_bin == 0);
          if (md_bin == FP-1) begin
            md_busy = 0; md_ptr = (md_owner + 1) % N; md_bin = 0;
          end else md_bin++;
        end
      end
      pipe_q.push_back(r);
      cur = pipe_q.pop_front();
      for (int k = 0; k < N; k++) begin
        if (exp_ready[k] && s_valid[k] && gen_frames[k] > 0) begin
          if (gen_pos[k] == gen_resof[k]) begin
            gen_pos[k] = 1; gen_resof[k] = -1;
          end else begin
            gen_pos[k]++;
            if (gen_pos[k] == FP) begin gen_pos[k] = 0; gen_frames[k]--; end
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = '1; s_sof = 4'b0101;
    for (int k = 0; k < N; k++) begin in_re[k] = 23'($urandom); in_im[k] = 23'($urandom); end
    pack_inputs();
    model_comb();
    advance();
    advance();
    checks++;
    if (s_ready !== '0) begin failures++; $display("FAIL rst_ready got=%b exp=0", s_ready); end
    checks++;
    if ({m_valid, m_lane, m_bin, m_sof, m_power, err} !== '0)
      begin failures++; $display("FAIL rst_outputs got v=%b l=%0d b=%0d s=%b p=%h e=%b exp all 0",
                                 m_valid, m_lane, m_bin, m_sof, m_power, err); end
    rst = 1'b0;
  endtask

  task automatic test_all_lanes();
    int res = 0, nsof = 0;
    gen_clear();
    for (int k = 0; k < N; k++) gen_frames[k] = 2;
    for (int cyc = 0; cyc < 4300 && res < 8*FP; cyc++) begin
      gen_inputs(); model_comb();
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL all_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if ({m_valid, err} !== {cur.v, md_err}) begin failures++; $display("FAIL all_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, m_valid, err, cur.v, md_err); end
      if (cur.v) begin
        checks++;
        if ({m_lane, m_bin, m_sof, m_power} !== {LW'(cur.lane), BW'(cur.bin), cur.sof, 48'(cur.pwr)})
          begin failures++; $display("FAIL all_data cyc=%0d got=%0d/%0d/%b/%h exp=%0d/%0d/%b/%h", cyc, m_lane, m_bin, m_sof, m_power, cur.lane, cur.bin, cur.sof, 48'(cur.pwr)); end
      end
      if (m_valid) begin
        if (m_sof) begin
          checks++;
          if (m_lane !== LW'(nsof % N)) begin failures++; $display("FAIL all_order frame=%0d got=%0d exp=%0d", nsof, m_lane, nsof % N); end
          nsof++;
        end
        res++;
      end
    end
    checks++;
    if (res != 8*FP || nsof != 8) begin failures++; $display("FAIL all_count got=%0d/%0d exp=%0d/8", res, nsof, 8*FP); end
  endtask

  task automatic test_single_frame();
    int res = 0, nsof = 0, first_beat = -1, first_out = -1;
    gen_clear();
    gen_frames[0] = 1; gen_fixed[0] = 1; gen_fre[0] = 3; gen_fim[0] = -4;
    for (int cyc = 0; cyc < 700 && res < FP; cyc++) begin
      gen_inputs(); model_comb();
      if (md_beat && first_beat < 0) first_beat = cyc;
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL one_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if (m_valid !== cur.v) begin failures++; $display("FAIL one_valid cyc=%0d got=%b exp=%b", cyc, m_valid, cur.v); end
      if (m_valid) begin
        if (first_out < 0) first_out = cyc + 1;
        checks++;
        if ({m_lane, m_bin, m_sof, m_power} !== {LW'(0), BW'(res), res == 0, 48'd25})
          begin failures++; $display("FAIL one_data idx=%0d got=%0d/%0d/%b/%0d exp=0/%0d/%b/25", res, m_lane, m_bin, m_sof, m_power, res, res == 0); end
        nsof += m_sof;
        res++;
      end
    end
    checks++;
    if (res != FP || nsof != 1) begin failures++; $display("FAIL one_count got=%0d/%0d exp=%0d/1", res, nsof, FP); end
    checks++;
    if (first_out - first_beat != 4) begin failures++; $display("FAIL one_latency got=%0d exp=4", first_out - first_beat); end
  endtask

  task automatic test_bubbles();
    int res = 0;
    gen_clear();
    gen_frames[2] = 1; gen_toggle[2] = 1;
    for (int cyc = 0; cyc < 1200 && res < FP; cyc++) begin
      gen_inputs(); model_comb();
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL bub_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if (m_valid !== cur.v) begin failures++; $display("FAIL bub_valid cyc=%0d got=%b exp=%b", cyc, m_valid, cur.v); end
      if (m_valid) begin
        checks++;
        if ({m_lane, m_bin, m_power} !== {LW'(2), BW'(res), 48'(cur.pwr)})
          begin failures++; $display("FAIL bub_data idx=%0d got=%0d/%0d/%h exp=2/%0d/%h", res, m_lane, m_bin, m_power, res, 48'(cur.pwr)); end
        res++;
      end
    end
    checks++;
    if (res != FP || err !== '0) begin failures++; $display("FAIL bub_end got=%0d err=%b exp=%0d err=0", res, err, FP); end
  endtask

  task automatic test_extreme();
    int res = 0;
    gen_clear();
    gen_frames[3] = 1; gen_fixed[3] = 1; gen_fre[3] = -4194304; gen_fim[3] = -4194304; gen_pv[3] = 70;
    for (int cyc = 0; cyc < 1500 && res < FP; cyc++) begin
      gen_inputs(); model_comb();
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL ext_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if (m_valid !== cur.v) begin failures++; $display("FAIL ext_valid cyc=%0d got=%b exp=%b", cyc, m_valid, cur.v); end
      if (m_valid) begin
        checks++;
        if ({m_lane, m_bin, m_power} !== {LW'(3), BW'(res), 48'h2000_0000_0000})
          begin failures++; $display("FAIL ext_data idx=%0d got=%0d/%0d/%h exp=3/%0d/200000000000", res, m_lane, m_bin, m_power, res); end
        res++;
      end
    end
    checks++;
    if (res != FP) begin failures++; $display("FAIL ext_count got=%0d exp=%0d", res, FP); end
  endtask

  task automatic test_framing();
    int res = 0;
    gen_clear();
    gen_frames[1] = 1; gen_resof[1] = 100;
    for (int cyc = 0; cyc < 800 && res < FP + 100; cyc++) begin
      gen_inputs(); model_comb();
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL frm_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if ({m_valid, err} !== {cur.v, md_err}) begin failures++; $display("FAIL frm_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, m_valid, err, cur.v, md_err); end
      if (m_valid) begin
        checks++;
        if ({m_lane, m_bin, m_sof, m_power} !== {LW'(1), BW'(res < 100 ? res : res - 100), res == 0 || res == 100, 48'(cur.pwr)})
          begin failures++; $display("FAIL frm_data idx=%0d got=%0d/%0d/%b/%h exp=1/%0d/%b/%h", res, m_lane, m_bin, m_sof, m_power, res < 100 ? res : res - 100, res == 0 || res == 100, 48'(cur.pwr)); end
        res++;
      end
    end
    checks++;
    if (res != FP + 100 || err !== 4'b0010) begin failures++; $display("FAIL frm_restart got=%0d err=%b exp=%0d err=0010", res, err, FP + 100); end
    // stray non-SOF sample on lane 3 while idle
    s_valid = 4'b1000; s_sof = '0;
    for (int k = 0; k < N; k++) begin in_re[k] = 23'($urandom); in_im[k] = 23'($urandom); end
    pack_inputs();
    model_comb();
    checks++;
    if (s_ready !== 4'b1000) begin failures++; $display("FAIL frm_drop_ready got=%b exp=1000", s_ready); end
    advance();
    for (int cyc = 0; cyc < 6; cyc++) begin
      gen_inputs(); model_comb(); advance();
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL frm_drop_valid cyc=%0d got=%b exp=0", cyc, m_valid); end
    end
    checks++;
    if (err !== 4'b1010) begin failures++; $display("FAIL frm_err got=%b exp=1010", err); end
  endtask

  task automatic test_rst_mid();
    int res = 0;
    gen_clear();
    gen_frames[2] = 1;
    for (int cyc = 0; cyc < 400 && gen_pos[2] != 200; cyc++) begin
      gen_inputs(); model_comb(); advance();
    end
    checks++;
    if (gen_pos[2] != 200) begin failures++; $display("FAIL rmid_reach got=%0d exp=200", gen_pos[2]); end
    rst = 1'b1;
    gen_inputs(); model_comb();
    checks++;
    if (s_ready !== '0) begin failures++; $display("FAIL rmid_ready got=%b exp=0", s_ready); end
    advance();
    checks++;
    if ({m_valid, m_lane, m_bin, m_sof, m_power, err} !== '0)
      begin failures++; $display("FAIL rmid_outputs got v=%b l=%0d b=%0d s=%b p=%h e=%b exp all 0", m_valid, m_lane, m_bin, m_sof, m_power, err); end
    rst = 1'b0;
    gen_clear();
    for (int cyc = 0; cyc < 8; cyc++) begin
      gen_inputs(); model_comb(); advance();
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale cyc=%0d got=%b exp=0", cyc, m_valid); end
    end
    gen_frames[0] = 1; gen_frames[2] = 1;
    for (int cyc = 0; cyc < 1200 && res < 2*FP; cyc++) begin
      gen_inputs(); model_comb();
      if (cyc == 0) begin
        checks++;
        if (s_ready !== 4'b0001) begin failures++; $display("FAIL rmid_grant got=%b exp=0001", s_ready); end
      end
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL rmid_ready2 cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if ({m_valid, err} !== {cur.v, md_err}) begin failures++; $display("FAIL rmid_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, m_valid, err, cur.v, md_err); end
      if (cur.v) begin
        checks++;
        if ({m_lane, m_bin, m_sof, m_power} !== {LW'(cur.lane), BW'(cur.bin), cur.sof, 48'(cur.pwr)})
          begin failures++; $display("FAIL rmid_data cyc=%0d got=%0d/%0d/%b/%h exp=%0d/%0d/%b/%h", cyc, m_lane, m_bin, m_sof, m_power, cur.lane, cur.bin, cur.sof, 48'(cur.pwr)); end
      end
      if (m_valid) res++;
    end
    checks++;
    if (res != 2*FP) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", res, 2*FP); end
  endtask

  task automatic test_random_traffic();
    int res = 0;
    gen_clear();
    for (int k = 0; k < N; k++) begin
      gen_frames[k] = 1;
      gen_pv[k] = $urandom_range(100, 40);
    end
    for (int cyc = 0; cyc < 8000 && res < N*FP; cyc++) begin
      gen_inputs(); model_comb();
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      advance();
      checks++;
      if ({m_valid, err} !== {cur.v, md_err}) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, m_valid, err, cur.v, md_err); end
      if (cur.v) begin
        checks++;
        if ({m_lane, m_bin, m_sof, m_power} !== {LW'(cur.lane), BW'(cur.bin), cur.sof, 48'(cur.pwr)})
          begin failures++; $display("FAIL rnd_data cyc=%0d got=%0d/%0d/%b/%h exp=%0d/%0d/%b/%h", cyc, m_lane, m_bin, m_sof, m_power, cur.lane, cur.bin, cur.sof, 48'(cur.pwr)); end
      end
      if (m_valid) res++;
    end
    checks++;
    if (res != N*FP) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", res, N*FP); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_valid = '0; s_sof = '0; s_re = '0; s_im = '0;
    gen_clear();
    test_reset();
    test_all_lanes();
    test_single_frame();
    test_bubbles();
    test_extreme();
    test_framing();
    test_rst_mid();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwr_lane_sched.md
# pwr_lane_sched

Frame-locked round-robin scheduler that shares one power datapath (re²+im², 4-cycle pipeline) between NUM_LANES FFT output lanes. It sits between the per-lane FFT cores and the spectrum accumulator. Each lane gets exclusive use of the squarer for one whole FFT frame at a time. The result stream carries lane id, bin index and start-of-frame tags aligned to the power value.

## Interface
- NUM_LANES, 4: FFT lanes sharing the datapath (2..8).
- FFT_POINT, 512: bins per frame; power of two.
- BIN_W, 9: log2(FFT_POINT).
- LANE_W, 2: ceil(log2(NUM_LANES)).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  NUM_LANES  per-lane sample valid.
- s_ready  out  NUM_LANES  per-lane accept; combinational from FSM state and s_valid/s_sof.
- s_sof  in  NUM_LANES  per-lane start-of-frame, marks bin 0.
- s_re  in  NUM_LANES*23  signed real parts; lane k at [23k+22:23k].
- s_im  in  NUM_LANES*23  signed imaginary parts, same packing.
- m_valid  out  1  result valid; no backpressure.
- m_lane  out  LANE_W  source lane of result.
- m_bin  out  BIN_W  bin index of result.
- m_sof  out  1  high with bin 0 of each frame.
- m_power  out  48  {1'b0, re²+im²}.
- err  out  NUM_LANES  sticky per-lane framing error.

## Operation
- Beat = s_valid[k] & s_ready[k]. At most one lane is ready in any cycle, except for IDLE discards.
- FSM states: IDLE, BURST.
- IDLE:
  - Search starts at ptr (reset 0). Grant the first lane k in round-robin order with s_valid[k] & s_sof[k].
  - On grant: g←k, state←BURST, s_ready[k]=1 in the same cycle, so the SOF beat is accepted as bin 0 and cnt←1.
  - Lanes with s_valid & !s_sof are discarded: s_ready=1, err[k]←1, no datapath entry.
  - Discards are evaluated for all lanes, including lanes other than the one granted that cycle.
- BURST:
  - s_ready[g]=1 and all other s_ready=0.
  - Each beat enters the datapath with tag {g, cnt, cnt==0}, then cnt←cnt+1.
  - A cycle with s_valid[g]=0 is a bubble; cnt holds.
- Frame end: on a beat with cnt==FFT_POINT-1, state←IDLE, ptr←(g+1) mod NUM_LANES, cnt←0.
- Mid-frame SOF: a beat on g with s_sof=1 and cnt≠0 sets err[g]←1. That beat is tagged bin 0 with m_sof=1, and cnt←1; the frame restarts and the grant is kept.
- Arithmetic:
  - re, im are two's complement 23-bit.
  - Products are 46-bit unsigned-valued; sum is 47-bit, zero-extended to 48.
  - No saturation. Worst case (-2^22)²·2 = 2^45 fits.
- err bits clear only on rst.

## Timing
- Latency: beat in cycle t → m_valid=1 with matching tags and power in cycle t+4 (3 multiply + 1 add). Tags ride a 4-stage shift register.
- Throughput: one sample per cycle within a burst. One arbitration cycle per frame in IDLE, unless the next grant is taken in that same IDLE cycle.
- Reset values: m_valid 0, m_lane 0, m_bin 0, m_sof 0, m_power 0, err 0, s_ready 0 during rst, state IDLE, ptr 0, cnt 0.
- Reset mid-burst: all in-flight pipeline stages cleared. m_valid=0 from the cycle after rst is sampled until 4 cycles after the next accepted beat.
- Simultaneous SOF on several lanes in IDLE: the lowest round-robin distance from ptr wins; the others stay stalled with s_ready=0.
- NUM_LANES=1: ptr stays 0, and back-to-back frames are separated by exactly one IDLE cycle.

## Structure
- Package pwr_sched_pkg holds:
  - DATA_W=23, PROD_W=46, PWR_W=48, PIPE_LAT=4.
  - Tag struct {lane, bin, sof}.
  - FSM state enum.
- Sub-module pwr_sq_pipe: squarer-adder with sclr. Two 23×23 signed multipliers (3 regs), one 46+46 adder (1 reg), 48-bit output.
- The top holds the FSM, round-robin pointer, bin counter, tag shift register and err logic.

## Test plan
- Single frame on lane 0: re=3, im=-4 for all 512 beats, SOF on the first. Required: 512 results, m_power=25, m_bin 0..511, m_sof only on the first result, first m_valid 4 cycles after the first beat.
- All 4 lanes present SOF at once, ptr=0. Required: frames serviced in order 0,1,2,3, each 512 beats. Second round starts at lane 0, with ptr advancing after each frame.
- Bubbles: lane 2 s_valid toggles every other cycle. Required: cnt holds across bubbles, m_bin contiguous, total 512 results, no error.
- Extreme value: re=-4194304, im=-4194304. Required: m_power=0x2000_0000_0000 (2^45).
- Framing: lane 1 SOF at bin 100 mid-burst, then lane 3 non-SOF in IDLE. Required: err[1]=1 and bin restarts at 0 with m_sof; err[3]=1 and the lane-3 sample is dropped.
- rst asserted at bin 200 of a burst. Required: all outputs 0 the next cycle, no stale m_valid afterwards, a new SOF grants lane 0.
